// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, response codes and FSM state encodings.
package axi_lite_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [STRB_W-1:0] strb_t;
    typedef logic [1:0]        resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_W,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/axi_lite_slave_mem.sv
// Word memory with one byte-strobed write port and one registered read port.
module axi_lite_slave_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned IDX_W      = 5
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    re,
    input  logic                    rzero,
    input  logic [IDX_W-1:0]        ridx,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read samples pre-write contents when both ports hit the same word on one edge.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                for (int b = 0; b < int'(NB); b++) begin
                    if (wstrb[b]) begin
                        mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            if (re) begin
                rdata <= rzero ? '0 : mem[ridx];
            end
        end
    end

endmodule

// File: rtl/axi_lite_slave.sv
// AXI4-Lite slave serving a byte-strobed word memory; independent read and write FSMs.
module axi_lite_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output resp_t                   bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output resp_t                   rresp,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> 2) < ADDR_WIDTH'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return off[2 +: IDX_W];
    endfunction

    wr_state_e               wr_state;
    rd_state_e               rd_state;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [STRB_WIDTH-1:0]   w_strb_q;

    logic                    aw_hs_c;
    logic                    w_hs_c;
    logic                    ar_hs_c;
    logic                    commit_c;
    logic                    wr_ok_c;
    logic                    rd_ok_c;
    logic [ADDR_WIDTH-1:0]   wr_addr_c;
    logic [DATA_WIDTH-1:0]   wr_data_c;
    logic [STRB_WIDTH-1:0]   wr_strb_c;

    assign aw_hs_c = awvalid && awready;
    assign w_hs_c  = wvalid && wready;
    assign ar_hs_c = arvalid && arready;
    assign wr_ok_c = addr_ok(wr_addr_c);
    assign rd_ok_c = addr_ok(araddr);

    // Select the address/data pair that completes on this edge, live or held.
    always_comb begin
        commit_c  = 1'b0;
        wr_addr_c = awaddr;
        wr_data_c = wdata;
        wr_strb_c = wstrb;
        case (wr_state)
            W_IDLE:   commit_c = aw_hs_c && w_hs_c;
            W_HAVE_A: begin
                commit_c  = w_hs_c;
                wr_addr_c = aw_addr_q;
            end
            W_HAVE_W: begin
                commit_c  = aw_hs_c;
                wr_data_c = w_data_q;
                wr_strb_c = w_strb_q;
            end
            default:  commit_c = 1'b0;
        endcase
    end

    // Write channel FSM with registered readies and response.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_state  <= W_IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (commit_c) begin
                wr_state <= W_RESP;
                awready  <= 1'b0;
                wready   <= 1'b0;
                bvalid   <= 1'b1;
                bresp    <= wr_ok_c ? RESP_OKAY : RESP_SLVERR;
            end else begin
                case (wr_state)
                    W_IDLE: begin
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        if (aw_hs_c) begin
                            wr_state  <= W_HAVE_A;
                            aw_addr_q <= awaddr;
                            awready   <= 1'b0;
                        end else if (w_hs_c) begin
                            wr_state <= W_HAVE_W;
                            w_data_q <= wdata;
                            w_strb_q <= wstrb;
                            wready   <= 1'b0;
                        end
                    end
                    W_HAVE_A: begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                    end
                    W_HAVE_W: begin
                        awready <= 1'b1;
                        wready  <= 1'b0;
                    end
                    W_RESP: begin
                        if (bready) begin
                            wr_state <= W_IDLE;
                            bvalid   <= 1'b0;
                            awready  <= 1'b1;
                            wready   <= 1'b1;
                        end
                    end
                    default: wr_state <= W_IDLE;
                endcase
            end
        end
    end

    // Read channel FSM; read data itself is registered inside the memory.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rd_state <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (ar_hs_c) begin
                        rd_state <= R_DATA;
                        arready  <= 1'b0;
                        rvalid   <= 1'b1;
                        rresp    <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rd_state <= R_IDLE;
                        rvalid   <= 1'b0;
                        arready  <= 1'b1;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    axi_lite_slave_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .aclk     (aclk),
        .areset_n (areset_n),
        .we       (commit_c && wr_ok_c),
        .widx     (addr_idx(wr_addr_c)),
        .wdata    (wr_data_c),
        .wstrb    (wr_strb_c),
        .re       (ar_hs_c),
        .rzero    (!rd_ok_c),
        .ridx     (addr_idx(araddr)),
        .rdata    (rdata)
    );

endmodule

// File: tb/tb_axi_lite_slave.sv
// Directed vector bench for axi_lite_slave: table of transactions plus hand-built corner sequences.
module tb_axi_lite_slave;

    logic        aclk;
    logic        areset_n;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vec [14];

    axi_lite_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (32),
        .BASE_ADDR  (32'h0)
    ) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Write with W presented lead cycles before AW (lead 0 = same cycle); starts and ends at a negedge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int lead, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_fire;
        bit w_fire;
        int cyc = 0;
        wvalid = 1'b1;
        wdata  = data;
        wstrb  = strb;
        awaddr = addr;
        while (!(aw_done && w_done) && cyc < 50) begin
            if (cyc == lead && !aw_done) awvalid = 1'b1;
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge aclk);
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done  = 1;
            @(negedge aclk);
            if (aw_fire) awvalid = 1'b0;
            if (w_fire)  wvalid  = 1'b0;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) chk("write handshake timeout", 32'(aw_done), 32'd1);
        chk("bvalid one cycle after write", 32'(bvalid), 32'd1);
        resp  = bresp;
        bready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cyc = 0;
        bit fire = 0;
        arvalid = 1'b1;
        araddr  = addr;
        while (!fire && cyc < 50) begin
            fire = arready;
            @(posedge aclk);
            @(negedge aclk);
            cyc++;
        end
        arvalid = 1'b0;
        if (!fire) chk("read handshake timeout", 32'(fire), 32'd1);
        chk("rvalid one cycle after AR", 32'(rvalid), 32'd1);
        data   = rdata;
        resp   = rresp;
        rready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        areset_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;

        vec[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 0, 2'b00, 32'h0};
        vec[1]  = '{1'b0, 32'h08, 32'h0,        4'h0, 0, 2'b00, 32'hDEADBEEF};
        vec[2]  = '{1'b1, 32'h08, 32'h00001234, 4'h3, 3, 2'b00, 32'h0};
        vec[3]  = '{1'b0, 32'h08, 32'h0,        4'h0, 0, 2'b00, 32'hDEAD1234};
        vec[4]  = '{1'b0, 32'h80, 32'h0,        4'h0, 0, 2'b10, 32'h0};
        vec[5]  = '{1'b1, 32'h80, 32'hFFFFFFFF, 4'hF, 0, 2'b10, 32'h0};
        vec[6]  = '{1'b0, 32'h00, 32'h0,        4'h0, 0, 2'b00, 32'h0};
        vec[7]  = '{1'b0, 32'h7C, 32'h0,        4'h0, 0, 2'b00, 32'h0};
        vec[8]  = '{1'b1, 32'h7C, 32'hA5A5A5A5, 4'h8, 0, 2'b00, 32'h0};
        vec[9]  = '{1'b0, 32'h7E, 32'h0,        4'h0, 0, 2'b00, 32'hA5000000};
        vec[10] = '{1'b1, 32'h10, 32'h12345678, 4'h0, 1, 2'b00, 32'h0};
        vec[11] = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 2'b00, 32'h0};
        vec[12] = '{1'b1, 32'h0C, 32'h00000011, 4'hF, 2, 2'b00, 32'h0};
        vec[13] = '{1'b0, 32'h0C, 32'h0,        4'h0, 0, 2'b00, 32'h00000011};

        // Reset values, then readies rise on the first edge after release.
        #12;
        chk("reset awready", 32'(awready), 32'd0);
        chk("reset bvalid",  32'(bvalid),  32'd0);
        chk("reset rvalid",  32'(rvalid),  32'd0);
        chk("reset rdata",   rdata,        32'd0);
        @(negedge aclk);
        areset_n = 1'b1;
        chk("ready before first edge", {29'd0, awready, wready, arready}, 32'd0);
        @(negedge aclk);
        chk("ready after first edge", {29'd0, awready, wready, arready}, 32'd7);

        for (int i = 0; i < 14; i++) begin
            if (vec[i].wr) begin
                axi_write(vec[i].addr, vec[i].data, vec[i].strb, vec[i].lead, r);
                chk($sformatf("vec%0d bresp", i), 32'(r), 32'(vec[i].resp));
            end else begin
                axi_read(vec[i].addr, d, r);
                chk($sformatf("vec%0d rresp", i), 32'(r), 32'(vec[i].resp));
                chk($sformatf("vec%0d rdata", i), d, vec[i].rdata);
            end
        end

        // Hold bready low for 5 cycles with a second AW pending.
        wvalid = 1'b1; wdata = 32'h0000_5555; wstrb = 4'hF;
        awvalid = 1'b1; awaddr = 32'h14;
        @(posedge aclk);
        @(negedge aclk);
        chk("stall first AW/W accepted", {30'd0, awready, wready}, 32'd0);
        wvalid = 1'b0;
        awaddr = 32'h18;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall c%0d bvalid", c), 32'(bvalid), 32'd1);
            chk($sformatf("stall c%0d bresp", c), 32'(bresp), 32'd0);
            chk($sformatf("stall c%0d readies", c), {30'd0, awready, wready}, 32'd0);
            @(posedge aclk);
            @(negedge aclk);
        end
        awvalid = 1'b0;
        bready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 1'b0;
        chk("stall bvalid cleared", 32'(bvalid), 32'd0);
        axi_read(32'h18, d, r);
        chk("stalled AW not written", d, 32'd0);
        axi_read(32'h14, d, r);
        chk("stall write data", d, 32'h0000_5555);

        // AR lands on the same edge as the write commit to 0x0C.
        wvalid = 1'b1; wdata = 32'h22; wstrb = 4'hF;
        @(posedge aclk);
        @(negedge aclk);
        wvalid = 1'b0;
        awvalid = 1'b1; awaddr = 32'h0C;
        arvalid = 1'b1; araddr = 32'h0C;
        chk("collision readies", {30'd0, awready, arready}, 32'd3);
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0; arvalid = 1'b0;
        chk("collision bvalid", 32'(bvalid), 32'd1);
        chk("collision rvalid", 32'(rvalid), 32'd1);
        chk("collision old data", rdata, 32'h11);
        bready = 1'b1; rready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 1'b0; rready = 1'b0;
        axi_read(32'h0C, d, r);
        chk("collision re-read", d, 32'h22);

        // Reset while a read response is outstanding.
        arvalid = 1'b1; araddr = 32'h08;
        @(posedge aclk);
        @(negedge aclk);
        arvalid = 1'b0;
        chk("pre-reset rvalid", 32'(rvalid), 32'd1);
        #1 areset_n = 1'b0;
        #1;
        chk("rvalid drops on reset", 32'(rvalid), 32'd0);
        @(negedge aclk);
        areset_n = 1'b1;
        @(negedge aclk);
        axi_read(32'h08, d, r);
        chk("post-reset rresp", 32'(r), 32'd0);
        chk("post-reset rdata", d, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
